adc_frame_packer: RTL and testbench

ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

---
 rtl/adc_frame_pkg.sv | 41 ++++
 rtl/adc_frame_packer_if.sv | 32 +++
 rtl/adc_frame_csum.sv | 29 ++
 rtl/adc_frame_packer.sv | 164 ++++++++++++++++
 tb/tb_adc_frame_packer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_frame_pkg.sv
// adc_frame_pkg: shared type codes, header field layout and FSM states
// for the ADC frame packer (HDR_W header, EXT_W extension word).
package adc_frame_pkg;

  localparam logic [7:0] T_SYNC   = 8'h01;
  localparam logic [7:0] T_PACK   = 8'h02;
  localparam logic [7:0] T_SAMPLE = 8'h03;
  localparam logic [7:0] T_FWD    = 8'h04;

  localparam int TYPE_LSB  = 0;
  localparam int TYPE_W    = 8;
  localparam int PNUM_LSB  = 8;
  localparam int PNUM_W    = 16;
  localparam int FNUM_LSB  = 24;
  localparam int FNUM_W    = 24;
  localparam int TS_LSB    = 48;
  localparam int TS_W      = 16;
  localparam int GAIN_LSB  = 64;
  localparam int GAIN_W    = 8;
  localparam int RATE_LSB  = 72;
  localparam int RATE_W    = 8;
  localparam int ASK_LSB   = 80;
  localparam int ASK_W     = 16;
  localparam int FDONE_LSB = 96;
  localparam int FDONE_W   = 8;

  localparam int HDR_W = 104;
  localparam int EXT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PACK,
    S_SAMPLE,
    S_DONE,
    S_FWD,
    S_ERROR,
    S_CSUM
  } state_e;

endpackage

// File: rtl/adc_frame_packer_if.sv
// adc_frame_packer_if: host command, sample and upstream frame signals.
// slave = packer side, master = host/ADC/upstream side.
interface adc_frame_packer_if
  import adc_frame_pkg::*;
#(
  parameter int N_CH     = 24,
  parameter int SAMPLE_W = 32
);
  localparam int FRAME_W = HDR_W + N_CH * SAMPLE_W + EXT_W;

  logic                     cmd_valid;
  logic [FRAME_W-1:0]       cmd_frame;
  logic                     cmd_ready;
  logic                     smp_valid;
  logic [N_CH*SAMPLE_W-1:0] smp_data;
  logic                     up_valid;
  logic                     up_ready;
  logic [FRAME_W-1:0]       up_frame;
  logic                     fwd_en;
  logic                     err;

  modport slave (
    input  cmd_valid, cmd_frame, smp_valid, smp_data, up_ready,
    output cmd_ready, up_valid, up_frame, fwd_en, err
  );

  modport master (
    output cmd_valid, cmd_frame, smp_valid, smp_data, up_ready,
    input  cmd_ready, up_valid, up_frame, fwd_en, err
  );

endinterface

// File: rtl/adc_frame_csum.sv
// adc_frame_csum: registered 16-bit modulo sum of all bytes of data_i.
// Ports: clk, rst (async high), data_i (frame body), sum_o (registered).
module adc_frame_csum #(
  parameter int DATA_W = 872
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  output logic [15:0]       sum_o
);

  logic [15:0] sum_d;
  logic [15:0] sum_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      sum_d = sum_d + 16'(data_i[i*8 +: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: command-driven FSM packing header + ADC samples into
// upstream frames. Ports: clk, rst (async high), bus (slave modport).
// Macro ADC_FRAME_CSUM_EN: byte checksum in extension, +1 cycle latency.
module adc_frame_packer
  import adc_frame_pkg::*;
#(
  parameter int N_CH           = 24,
  parameter int SAMPLE_W       = 32,
  parameter int FRAMES_PER_SEC = 2000,
  parameter int SAMPLE_TIMEOUT = 16384
) (
  input logic               clk,
  input logic               rst,
  adc_frame_packer_if.slave bus
);

  localparam int FRAME_W = HDR_W + N_CH * SAMPLE_W + EXT_W;
  localparam int PAY_W   = N_CH * SAMPLE_W;
  localparam int BODY_W  = FRAME_W - EXT_W;
  localparam int CMD_W   = RATE_LSB + RATE_W;
  localparam int CNT_W   = $clog2(SAMPLE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_TIMEOUT - 1);
  localparam logic [FNUM_W-1:0] FPS_V    = FNUM_W'(FRAMES_PER_SEC);
  localparam logic [FRAME_W-1:0] PAD =
    FRAME_W'({((FRAME_W + 7) / 8){8'h55}});

`ifdef ADC_FRAME_CSUM_EN
  localparam state_e S_POST = S_CSUM;
`else
  localparam state_e S_POST = S_DONE;
`endif

  state_e              state_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [PNUM_W-1:0]   pnum_q;
  logic [FNUM_W-1:0]   fnum_q;
  logic [TS_W-1:0]     ts_q;
  logic [GAIN_W-1:0]   gain_q;
  logic [RATE_W-1:0]   rate_q;
  logic [ASK_W-1:0]    ask_q;
  logic [PAY_W-1:0]    smp_q;
  logic                is_smp_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [TYPE_W-1:0]   cmd_type;
  logic [BODY_W-1:0]   body;
  logic [EXT_W-1:0]    ext;
  logic                unused_bits;

  assign cmd_type = bus.cmd_frame[TYPE_LSB +: TYPE_W];
  assign unused_bits = ^{bus.cmd_frame[FRAME_W-1:CMD_W],
                         cmd_q[FNUM_LSB +: FNUM_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      pnum_q   <= '0;
      fnum_q   <= '0;
      ts_q     <= '0;
      gain_q   <= '0;
      rate_q   <= '0;
      ask_q    <= '0;
      smp_q    <= '0;
      is_smp_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_q    <= bus.cmd_frame[CMD_W-1:0];
            is_smp_q <= (cmd_type == T_SAMPLE);
            cnt_q    <= '0;
            unique case (1'b1)
              cmd_type == T_SYNC:   state_q <= S_SYNC;
              cmd_type == T_PACK:   state_q <= S_PACK;
              cmd_type == T_SAMPLE: state_q <= S_SAMPLE;
              cmd_type == T_FWD:    state_q <= S_FWD;
              default:              state_q <= S_ERROR;
            endcase
          end
        end
        S_SYNC: begin
          ts_q        <= cmd_q[TS_LSB +: TS_W];
          ask_q[15:8] <= 8'h01;
          state_q     <= S_POST;
        end
        S_PACK: begin
          pnum_q     <= cmd_q[PNUM_LSB +: PNUM_W];
          gain_q     <= cmd_q[GAIN_LSB +: GAIN_W];
          rate_q     <= cmd_q[RATE_LSB +: RATE_W];
          ask_q[7:0] <= 8'h01;
          state_q    <= S_POST;
        end
        S_SAMPLE: begin
          // a sample arriving on the timeout cycle still wins
          if (bus.smp_valid) begin
            smp_q   <= bus.smp_data;
            fnum_q  <= fnum_q + 1'b1;
            state_q <= S_POST;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_ERROR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CSUM: state_q <= S_DONE;
        S_DONE: begin
          if (bus.up_ready) begin
            // one-second block complete: restart numbering
            if (is_smp_q && fnum_q == FPS_V) fnum_q <= '0;
            state_q <= S_IDLE;
          end
        end
        S_FWD:   state_q <= S_IDLE;
        S_ERROR: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    body = '0;
    body[TYPE_LSB  +: TYPE_W]  = cmd_q[TYPE_LSB +: TYPE_W];
    body[PNUM_LSB  +: PNUM_W]  = pnum_q;
    body[FNUM_LSB  +: FNUM_W]  = fnum_q;
    body[TS_LSB    +: TS_W]    = ts_q;
    body[GAIN_LSB  +: GAIN_W]  = gain_q;
    body[RATE_LSB  +: RATE_W]  = rate_q;
    body[ASK_LSB   +: ASK_W]   = ask_q;
    body[FDONE_LSB +: FDONE_W] =
      (fnum_q == FPS_V) ? FDONE_W'(1) : '0;
    // channel 0 sits at the top of the payload
    if (is_smp_q) begin
      for (int k = 0; k < N_CH; k++) begin
        body[HDR_W + (N_CH - 1 - k) * SAMPLE_W +: SAMPLE_W] =
          smp_q[k * SAMPLE_W +: SAMPLE_W];
      end
    end
  end

`ifdef ADC_FRAME_CSUM_EN
  logic [15:0] csum;

  adc_frame_csum #(.DATA_W(BODY_W)) u_csum (
    .clk    (clk),
    .rst    (rst),
    .data_i (body),
    .sum_o  (csum)
  );

  assign ext = {16'h0000, csum};
`else
  assign ext = '0;
`endif

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.up_valid  = (state_q == S_DONE);
  assign bus.fwd_en    = (state_q == S_FWD);
  assign bus.err       = (state_q == S_ERROR);
  assign bus.up_frame  = bus.up_valid ? {ext, body} : PAD;

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: directed checks of adc_frame_packer
// (default parameters: 24 x 32-bit channels, 904-bit frames).
module tb_adc_frame_packer;

  localparam int N_CH = 24;
  localparam int SW   = 32;
  localparam int FW   = 904;
  localparam int TO   = 16384;
  localparam int FPS  = 2000;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [FW-1:0]      pad;
  logic [FW-1:0]      snap;
  logic [N_CH*SW-1:0] d;
  int                 n;

  always #5 clk = ~clk;

  adc_frame_packer_if #(.N_CH(N_CH), .SAMPLE_W(SW)) bus ();

  adc_frame_packer #(
    .N_CH(N_CH), .SAMPLE_W(SW),
    .FRAMES_PER_SEC(FPS), .SAMPLE_TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [63:0] fld(input logic [FW-1:0] f,
                                      input int lsb, input int w);
    return 64'(f >> lsb) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] ch(input int k);
    return fld(bus.up_frame, 104 + (N_CH - 1 - k) * SW, SW);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef ADC_FRAME_CSUM_EN
  function automatic logic [15:0] bsum(input logic [FW-1:0] f);
    logic [15:0] s = '0;
    for (int i = 0; i < 109; i++) s = s + 16'(f[i*8 +: 8]);
    return s;
  endfunction
`endif

  task automatic chk_ext(input string tag);
`ifdef ADC_FRAME_CSUM_EN
    chk(tag, fld(bus.up_frame, 872, 32), {48'd0, bsum(bus.up_frame)});
`else
    chk(tag, fld(bus.up_frame, 872, 32), 64'd0);
`endif
  endtask

  task automatic send(input logic [7:0] t, input logic [79:0] hi);
    logic [FW-1:0] c;
    c = '0;
    c[79:0] = hi;
    c[7:0] = t;
    @(negedge clk);
    chk("cmd_ready_pre", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_frame = c;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_frame = '0;
  endtask

  task automatic wait_up(input string tag);
    int k = 0;
    while (!bus.up_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk(tag, bus.up_valid, 1);
  endtask

  task automatic accept();
    bus.up_ready = 1'b1;
    @(negedge clk);
    bus.up_ready = 1'b0;
    chk("up_drop", bus.up_valid, 0);
    chk("ready_back", bus.cmd_ready, 1);
  endtask

  task automatic do_sample(input logic [N_CH*SW-1:0] s);
    send(8'h03, '0);
    bus.smp_valid = 1'b1;
    bus.smp_data  = s;
    @(negedge clk);
    bus.smp_valid = 1'b0;
    wait_up("smp_up");
  endtask

  initial begin
    pad = {113{8'h55}};
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_frame = '0;
    bus.smp_valid = 1'b0;
    bus.smp_data  = '0;
    bus.up_ready  = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_up_valid", bus.up_valid, 0);
    chk("rst_fwd", bus.fwd_en, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_pad", bus.up_frame === pad, 1);
    rst = 1'b0;

    // SYNC: only timestamp taken, other cmd bits ignored
    send(8'h01, {16'hBEEF, 16'h1234, 24'h0, 16'h7777, 8'h00});
    wait_up("sync_up");
    chk("sync_type", fld(bus.up_frame, 0, 8), 8'h01);
    chk("sync_ts", fld(bus.up_frame, 48, 16), 16'h1234);
    chk("sync_ask", fld(bus.up_frame, 80, 16), 16'h0100);
    chk("sync_pnum", fld(bus.up_frame, 8, 16), 0);
    chk("sync_gain", fld(bus.up_frame, 64, 8), 0);
    chk("sync_fnum", fld(bus.up_frame, 24, 24), 0);
    chk("sync_fdone", fld(bus.up_frame, 96, 8), 0);
    chk("sync_pay0", |bus.up_frame[871:104], 0);
    chk_ext("sync_ext");
    repeat (3) @(negedge clk);
    chk("sync_hold", bus.up_valid, 1);
    accept();
    chk("idle_pad", bus.up_frame === pad, 1);

    // PACK
    send(8'h02, {8'h02, 8'h10, 16'h9999, 24'h0, 16'h0001, 8'h00});
    wait_up("pack_up");
    chk("pack_type", fld(bus.up_frame, 0, 8), 8'h02);
    chk("pack_pnum", fld(bus.up_frame, 8, 16), 16'h0001);
    chk("pack_gain", fld(bus.up_frame, 64, 8), 8'h10);
    chk("pack_rate", fld(bus.up_frame, 72, 8), 8'h02);
    chk("pack_ask", fld(bus.up_frame, 80, 16), 16'h0101);
    chk("pack_ts", fld(bus.up_frame, 48, 16), 16'h1234);
    chk("pack_pay0", |bus.up_frame[871:104], 0);
    chk_ext("pack_ext");
    accept();

    // SAMPLE with upstream stalled 10 cycles
    d = '0;
    d[31:0] = 32'hA5A5A5A5;
    d[5*SW +: SW] = 32'h00000005;
    d[23*SW +: SW] = 32'h11223344;
    do_sample(d);
    chk("smp_type", fld(bus.up_frame, 0, 8), 8'h03);
    chk("smp_ch0", fld(bus.up_frame, 840, 32), 32'hA5A5A5A5);
    chk("smp_ch5", ch(5), 32'h5);
    chk("smp_ch23", fld(bus.up_frame, 104, 32), 32'h11223344);
    chk("smp_fnum", fld(bus.up_frame, 24, 24), 1);
    chk("smp_gain", fld(bus.up_frame, 64, 8), 8'h10);
    chk_ext("smp_ext");
    snap = bus.up_frame;
    for (int i = 0; i < 10; i++) begin
      bus.smp_valid = (i == 3);
      bus.smp_data  = {(N_CH*SW/8){8'hEE}};
      @(negedge clk);
      chk("smp_stable", bus.up_frame === snap, 1);
    end
    bus.smp_valid = 1'b0;
    chk("smp_ch0_held", fld(bus.up_frame, 840, 32), 32'hA5A5A5A5);
    accept();

    // bad type -> err pulse
    send(8'h07, '0);
    chk("bad_err", bus.err, 1);
    chk("bad_fwd", bus.fwd_en, 0);
    chk("bad_upv", bus.up_valid, 0);
    @(negedge clk);
    chk("bad_err_end", bus.err, 0);
    chk("bad_ready", bus.cmd_ready, 1);

    // FWD -> fwd_en pulse
    send(8'h04, '0);
    chk("fwd_en", bus.fwd_en, 1);
    chk("fwd_err", bus.err, 0);
    @(negedge clk);
    chk("fwd_end", bus.fwd_en, 0);
    chk("fwd_ready", bus.cmd_ready, 1);

    // sample timeout
    send(8'h03, '0);
    n = 0;
    while (!bus.err && n < TO + 8) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_err", bus.err, 1);
    @(negedge clk);
    chk("to_ready", bus.cmd_ready, 1);

    // sample on the last timeout cycle wins
    send(8'h03, '0);
    repeat (TO - 1) @(negedge clk);
    d = '0;
    d[31:0] = 32'h0BADF00D;
    bus.smp_valid = 1'b1;
    bus.smp_data  = d;
    @(negedge clk);
    bus.smp_valid = 1'b0;
    chk("race_no_err", bus.err, 0);
    wait_up("race_up");
    chk("race_fnum", fld(bus.up_frame, 24, 24), 2);
    chk("race_ch0", ch(0), 32'h0BADF00D);
    accept();

    // run to the end of the one-second block
    for (int i = 3; i <= FPS; i++) begin
      d = '0;
      d[31:0] = 32'(i);
      do_sample(d);
      if (i == FPS - 1) begin
        chk("f1999_fnum", fld(bus.up_frame, 24, 24), FPS - 1);
        chk("f1999_done", fld(bus.up_frame, 96, 8), 0);
      end
      if (i == FPS) begin
        chk("f2000_fnum", fld(bus.up_frame, 24, 24), FPS);
        chk("f2000_done", fld(bus.up_frame, 96, 8), 1);
        chk("f2000_ch0", ch(0), FPS);
      end
      accept();
    end
    do_sample('0);
    chk("wrap_fnum", fld(bus.up_frame, 24, 24), 1);
    chk("wrap_done", fld(bus.up_frame, 96, 8), 0);
    accept();

    // reset in the middle of DONE
    send(8'h01, {16'h0, 16'hCAFE, 48'h0});
    wait_up("pre_rst_up");
    #2 rst = 1'b1;
    #1;
    chk("mrst_upv", bus.up_valid, 0);
    chk("mrst_ready", bus.cmd_ready, 1);
    chk("mrst_pad", bus.up_frame === pad, 1);
    @(negedge clk);
    rst = 1'b0;
    do_sample('0);
    chk("post_rst_fnum", fld(bus.up_frame, 24, 24), 1);
    chk("post_rst_ts", fld(bus.up_frame, 48, 16), 0);
    chk("post_rst_gain", fld(bus.up_frame, 64, 8), 0);
    accept();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
